// File: rtl/muladd_pkg.sv
// muladd_pkg: shared state enum, default width and counter sizing for the muladd engine
package muladd_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int DEF_W = 32;
    localparam int CNT_W = $clog2(DEF_W);

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/muladd_if.sv
// muladd_if: start/operand/result bundle between a requester (master) and the muladd engine (slave)
interface muladd_if #(parameter int W = muladd_pkg::DEF_W);

    logic           en;
    logic [W-1:0]   a;
    logic [W-1:0]   x;
    logic [W-1:0]   c;
    logic [2*W-1:0] p;
    logic           busy;
    logic           done;

    modport master (output en, a, x, c, input p, busy, done);
    modport slave  (input en, a, x, c, output p, busy, done);

endinterface

// File: rtl/muladd_step.sv
// muladd_step: one radix-2 shift-add step; adds a when lo[0] is set, then shifts {carry, hi, lo} right by one
module muladd_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] hi_i,
    input  logic [W-1:0] lo_i,
    input  logic [W-1:0] a_i,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);

    logic [W:0] sum;

    // conditional add into the upper half, carry kept in sum[W] and shifted back in
    always_comb begin
        sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, a_i} : '0);
        hi_o = sum[W:1];
        lo_o = {sum[0], lo_i[W-1:1]};
    end

endmodule

// File: rtl/muladd.sv
// muladd: sequential p = a*x + c over W cycles, en/done handshake; MULADD_ACC_EN enables the addend path (else p = a*x)
module muladd
    import muladd_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic     clk,
    input  logic     rst,
    muladd_if.slave  s
);

    localparam int CW = cnt_width(W);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic [W-1:0]   hi_n, lo_n;
    logic [2*W-1:0] p_q, p_d;
    logic [2*W-1:0] res;
    logic           done_q, done_d;

    muladd_step #(.W(W)) u_step (
        .hi_i (hi_q),
        .lo_i (lo_q),
        .a_i  (a_q),
        .hi_o (hi_n),
        .lo_o (lo_n)
    );

`ifdef MULADD_ACC_EN
    logic [W-1:0] c_q, c_d;

    // addend folded in once on the final step; a*x + c cannot exceed 2W bits
    assign res = {hi_n, lo_n} + {{W{1'b0}}, c_q};

    // addend register, loaded only when an operation is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) c_q <= '0;
        else     c_q <= c_d;
    end

    assign c_d = (state_q == IDLE && s.en) ? s.c : c_q;
`else
    assign res = {hi_n, lo_n};
`endif

    // state, counter and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            p_q     <= p_d;
            done_q  <= done_d;
        end
    end

    // IDLE accepts en and latches operands; RUN steps once per cycle and publishes on the last step
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        p_d     = p_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (s.en) begin
                state_d = RUN;
                cnt_d   = '0;
                a_d     = s.a;
                hi_d    = '0;
                lo_d    = s.x;
            end
        end else begin
            hi_d  = hi_n;
            lo_d  = lo_n;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
                state_d = IDLE;
                p_d     = res;
                done_d  = 1'b1;
            end
        end
    end

    assign s.p    = p_q;
    assign s.busy = (state_q == RUN);
    assign s.done = done_q;

endmodule
